// File: rtl/pipelined_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_nbit
// Brief    : WIDTH-bit ripple-carry adder pipelined in CHUNK-bit stages with a
//            valid/ready handshake, carry-out and signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("pipelined_adder_nbit: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    // Inputs seen by each stage: index 0 is the port side, index k is stage k-1's register.
    logic             w_in_valid [STAGES];
    logic [WIDTH-1:0] w_in_a     [STAGES];
    logic [WIDTH-1:0] w_in_b     [STAGES];
    logic [WIDTH-1:0] w_in_sum   [STAGES];
    logic             w_in_c     [STAGES];
    logic             w_adv;

    // The whole pipe moves as one; no in_valid term keeps in_ready free of input paths.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_in_valid[0] = in_valid;
    assign w_in_a[0]     = A;
    assign w_in_b[0]     = B;
    assign w_in_sum[0]   = '0;
    assign w_in_c[0]     = Cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   w_chunk;
        logic [WIDTH-1:0] w_nsum;

        assign w_chunk = {1'b0, w_in_a[k][k*CHUNK +: CHUNK]}
                       + {1'b0, w_in_b[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, w_in_c[k]};

        always_comb begin
            w_nsum = w_in_sum[k];
            w_nsum[k*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic             r_valid;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_sum;
            logic             r_carry;

            // Data only loads with a valid slot so bubbles never disturb stored values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_sum   <= '0;
                    r_carry <= 1'b0;
                end else if (w_adv) begin
                    r_valid <= w_in_valid[k];
                    if (w_in_valid[k]) begin
                        r_a     <= w_in_a[k];
                        r_b     <= w_in_b[k];
                        r_sum   <= w_nsum;
                        r_carry <= w_chunk[CHUNK];
                    end
                end
            end

            assign w_in_valid[k+1] = r_valid;
            assign w_in_a[k+1]     = r_a;
            assign w_in_b[k+1]     = r_b;
            assign w_in_sum[k+1]   = r_sum;
            assign w_in_c[k+1]     = r_carry;
        end else begin : g_last
            logic             r_out_valid;
            logic [WIDTH-1:0] r_s;
            logic             r_cout;
            logic             r_ovf;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_valid <= 1'b0;
                    r_s         <= '0;
                    r_cout      <= 1'b0;
                    r_ovf       <= 1'b0;
                end else if (w_adv) begin
                    r_out_valid <= w_in_valid[k];
                    if (w_in_valid[k]) begin
                        r_s    <= w_nsum;
                        r_cout <= w_chunk[CHUNK];
                        r_ovf  <= (w_in_a[k][WIDTH-1] == w_in_b[k][WIDTH-1])
                               && (w_nsum[WIDTH-1] != w_in_a[k][WIDTH-1]);
                    end
                end
            end

            assign out_valid = r_out_valid;
            assign S         = r_s;
            assign Cout      = r_cout;
            assign Ovf       = r_ovf;
        end
    end

endmodule
`default_nettype wire
